// File: rtl/mp_avm_port_arbiter_pkg.sv
// rtl/mp_avm_port_arbiter_pkg.sv - shared defaults and port-ID width helper for the Avalon port arbiter
package mp_avm_port_arbiter_pkg;

  localparam int DEF_NUM_PORTS   = 2;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_BE_WIDTH    = DEF_DATA_WIDTH / 8;
  localparam int DEF_MAX_PENDING = 4;

  // Port-ID width: clog2(n), never less than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_id_fifo.sv
// rtl/mp_id_fifo.sv - in-order FIFO of issuing port IDs for outstanding reads
module mp_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_id_i,
  input  logic         pop_i,
  output logic [W-1:0] head_id_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         push_ok;
  logic         pop_ok;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign head_id_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= push_id_i;
  end

endmodule

// File: rtl/mp_avm_port_arbiter.sv
// rtl/mp_avm_port_arbiter.sv - round-robin sharing of one Avalon-MM master among request ports
module mp_avm_port_arbiter
  import mp_avm_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BE_WIDTH    = DEF_BE_WIDTH,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]            req_write_en,
  input  logic [NUM_PORTS-1:0]            req_read_en,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]   req_byte_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_write_data,
  output logic [NUM_PORTS-1:0]            req_grant,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_read_data,
  output logic [ADDR_WIDTH-1:0]           avm_address,
  output logic                            avm_write,
  output logic                            avm_read,
  output logic [BE_WIDTH-1:0]             avm_byteenable,
  output logic [DATA_WIDTH-1:0]           avm_writedata,
  input  logic                            avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]           avm_readdata,
  input  logic                            avm_readdatavalid,
  output logic                            protocol_err
);

  localparam int IDW = id_width(NUM_PORTS);
  localparam logic [IDW:0] NP = (IDW+1)'(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  logic [ADDR_WIDTH-1:0] avm_address_q;
  logic                  avm_write_q;
  logic                  avm_read_q;
  logic [BE_WIDTH-1:0]   avm_byteenable_q;
  logic [DATA_WIDTH-1:0] avm_writedata_q;
  logic [NUM_PORTS-1:0]  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_read_data_q;
  logic                  protocol_err_q;
  logic [IDW-1:0]        rr_q;
  logic [IDW-1:0]        rr_d;

  logic                  slot_free;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IDW-1:0]        head_id;
  logic [NUM_PORTS-1:0]  eligible;
  logic                  gnt_found;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW:0]          cand;
  logic                  grant_valid;
  logic                  gnt_is_write;
  logic                  push;
  logic                  pop;

  // The registered full flag is used on purpose: a read freed by a pop is granted one cycle later.
  assign eligible    = req_write_en | (req_read_en & {NUM_PORTS{!fifo_full}});
  assign slot_free   = !(avm_read_q || avm_write_q) || !avm_waitrequest;
  assign grant_valid = slot_free && (|eligible) && !reset;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (!gnt_found && eligible[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign rr_d         = (gnt_idx == IDW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_is_write = req_write_en[gnt_idx];
  assign req_grant    = grant_valid ? (ONE << gnt_idx) : '0;
  assign push         = grant_valid && !gnt_is_write;
  assign pop          = avm_readdatavalid && !fifo_empty;

  mp_id_fifo #(
    .DEPTH (MAX_PENDING),
    .W     (IDW)
  ) u_id_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .push_i    (push),
    .push_id_i (gnt_idx),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm_address_q    <= '0;
      avm_write_q      <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_byteenable_q <= '0;
      avm_writedata_q  <= '0;
      resp_valid_q     <= '0;
      resp_read_data_q <= '0;
      protocol_err_q   <= 1'b0;
      rr_q             <= '0;
    end else begin
      if (grant_valid) begin
        avm_address_q    <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        avm_byteenable_q <= req_byte_en[gnt_idx*BE_WIDTH +: BE_WIDTH];
        avm_writedata_q  <= req_write_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        avm_write_q      <= gnt_is_write;
        avm_read_q       <= !gnt_is_write;
        rr_q             <= rr_d;
      end else if (slot_free) begin
        avm_write_q <= 1'b0;
        avm_read_q  <= 1'b0;
      end
      resp_valid_q <= pop ? (ONE << head_id) : '0;
      if (pop) resp_read_data_q <= avm_readdata;
      if (avm_readdatavalid && fifo_empty) protocol_err_q <= 1'b1;
    end
  end

  assign avm_address    = avm_address_q;
  assign avm_write      = avm_write_q;
  assign avm_read       = avm_read_q;
  assign avm_byteenable = avm_byteenable_q;
  assign avm_writedata  = avm_writedata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_read_data = resp_read_data_q;
  assign protocol_err   = protocol_err_q;

endmodule

// File: tb/tb_mp_avm_port_arbiter.sv
// tb/tb_mp_avm_port_arbiter.sv - directed self-checking bench for mp_avm_port_arbiter
module tb_mp_avm_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int MP = 4;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NP*AW-1:0]   req_addr = '0;
  logic [NP-1:0]      req_write_en = '0;
  logic [NP-1:0]      req_read_en = '0;
  logic [NP*BW-1:0]   req_byte_en = '0;
  logic [NP*DW-1:0]   req_write_data = '0;
  logic [NP-1:0]      req_grant;
  logic [NP-1:0]      resp_valid;
  logic [DW-1:0]      resp_read_data;
  logic [AW-1:0]      avm_address;
  logic               avm_write;
  logic               avm_read;
  logic [BW-1:0]      avm_byteenable;
  logic [DW-1:0]      avm_writedata;
  logic               avm_waitrequest = 1'b0;
  logic [DW-1:0]      avm_readdata = '0;
  logic               avm_readdatavalid = 1'b0;
  logic               protocol_err;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  mp_avm_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_PENDING(MP)
  ) dut (
    .clock(clock), .reset(reset),
    .req_addr(req_addr), .req_write_en(req_write_en), .req_read_en(req_read_en),
    .req_byte_en(req_byte_en), .req_write_data(req_write_data),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_read_data(resp_read_data),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .protocol_err(protocol_err)
  );

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({req_grant, resp_valid, avm_read, avm_write, protocol_err} !== 7'b0 ||
        avm_address !== '0 || resp_read_data !== '0) begin
      $display("FAIL reset_outputs: grant=%b rv=%b rd=%b wr=%b err=%b addr=%h, required all 0",
               req_grant, resp_valid, avm_read, avm_write, protocol_err, avm_address);
    end else passed++;
    reset = 1'b0;
  endtask

  task automatic test_two_reads();
    @(negedge clock);
    req_addr[0*AW +: AW] = 32'h7f;
    req_addr[1*AW +: AW] = 32'hff;
    req_read_en = 2'b11;
    #1;
    checks++;
    if (req_grant !== 2'b01) $display("FAIL rd_grant0: got %b required 01", req_grant); else passed++;
    @(posedge clock); #1;
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h7f)
      $display("FAIL rd_avm0: read=%b addr=%h required 1/0000007f", avm_read, avm_address);
    else passed++;
    @(negedge clock);
    #1;
    checks++;
    if (req_grant !== 2'b10) $display("FAIL rd_grant1: got %b required 10", req_grant); else passed++;
    @(posedge clock); #1;
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'hff)
      $display("FAIL rd_avm1: read=%b addr=%h required 1/000000ff", avm_read, avm_address);
    else passed++;
    @(negedge clock);
    req_read_en = 2'b00;
    @(posedge clock); #1;
    checks++;
    if (avm_read !== 1'b0) $display("FAIL rd_drop: read=%b required 0", avm_read); else passed++;
  endtask

  task automatic test_read_responses();
    @(negedge clock);
    avm_readdatavalid = 1'b1;
    avm_readdata = 64'hdeadbeef;
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 2'b01 || resp_read_data !== 64'hdeadbeef)
      $display("FAIL resp0: rv=%b data=%h required 01/deadbeef", resp_valid, resp_read_data);
    else passed++;
    @(negedge clock);
    avm_readdata = 64'hbeefdead;
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 2'b10 || resp_read_data !== 64'hbeefdead)
      $display("FAIL resp1: rv=%b data=%h required 10/beefdead", resp_valid, resp_read_data);
    else passed++;
    @(negedge clock);
    avm_readdatavalid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (resp_valid !== 2'b00 || protocol_err !== 1'b0)
      $display("FAIL resp_end: rv=%b err=%b required 00/0", resp_valid, protocol_err);
    else passed++;
  endtask

  task automatic test_waitrequest_hold();
    @(negedge clock);
    req_addr[1*AW +: AW] = 32'h1ff;
    req_write_data[1*DW +: DW] = 64'h0123456789abcdef;
    req_byte_en[1*BW +: BW] = 8'h0f;
    req_write_en = 2'b10;
    avm_waitrequest = 1'b1;
    #1;
    checks++;
    if (req_grant !== 2'b10) $display("FAIL wr_grant: got %b required 10", req_grant); else passed++;
    @(posedge clock);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      req_write_en = 2'b00;
      req_read_en = (c < 4) ? 2'b01 : 2'b00;
      avm_waitrequest = (c < 4);
      #1;
      checks++;
      if (avm_write !== 1'b1 || avm_address !== 32'h1ff || avm_writedata !== 64'h0123456789abcdef ||
          avm_byteenable !== 8'h0f || req_grant !== 2'b00)
        $display("FAIL wr_hold c%0d: wr=%b addr=%h data=%h be=%h grant=%b required 1/1ff/0123456789abcdef/0f/00",
                 c, avm_write, avm_address, avm_writedata, avm_byteenable, req_grant);
      else passed++;
      @(posedge clock);
    end
    #1;
    checks++;
    if (avm_write !== 1'b0) $display("FAIL wr_drop: wr=%b required 0", avm_write); else passed++;
  endtask

  task automatic test_back_to_back();
    int cnt0 = 0;
    int cnt1 = 0;
    int e;
    @(negedge clock);
    req_addr[0*AW +: AW] = 32'h100;
    req_addr[1*AW +: AW] = 32'h200;
    req_write_en = 2'b11;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      e = c % 2;
      #1;
      checks++;
      if (req_grant !== (2'b01 << e)) $display("FAIL rr_grant c%0d: got %b required port %0d", c, req_grant, e);
      else passed++;
      if (req_grant == 2'b01) cnt0++;
      if (req_grant == 2'b10) cnt1++;
      @(posedge clock); #1;
      checks++;
      if (avm_write !== 1'b1 || avm_address !== (e == 1 ? 32'h200 : 32'h100))
        $display("FAIL rr_avm c%0d: wr=%b addr=%h required port %0d address", c, avm_write, avm_address, e);
      else passed++;
    end
    checks++;
    if (cnt0 !== 4 || cnt1 !== 4) $display("FAIL rr_counts: got %0d/%0d required 4/4", cnt0, cnt1);
    else passed++;
    @(negedge clock);
    req_write_en = 2'b00;
    @(posedge clock); #1;
  endtask

  task automatic test_fifo_full();
    @(negedge clock);
    req_addr[0*AW +: AW] = 32'h40;
    req_read_en = 2'b01;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clock);
      req_write_en = (c == 4) ? 2'b10 : 2'b00;
      avm_readdatavalid = (c == 6);
      avm_readdata = 64'h5a5a;
      #1;
      checks++;
      if (c < 4 || c == 7) begin
        if (req_grant !== 2'b01) $display("FAIL full_grant c%0d: got %b required 01", c, req_grant);
        else passed++;
      end else if (c == 4) begin
        if (req_grant !== 2'b10) $display("FAIL full_write c%0d: got %b required 10", c, req_grant);
        else passed++;
      end else begin
        if (req_grant !== 2'b00) $display("FAIL full_block c%0d: got %b required 00", c, req_grant);
        else passed++;
      end
      @(posedge clock); #1;
      if (c == 6) begin
        checks++;
        if (resp_valid !== 2'b01 || resp_read_data !== 64'h5a5a)
          $display("FAIL full_resp: rv=%b data=%h required 01/5a5a", resp_valid, resp_read_data);
        else passed++;
      end
    end
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h40)
      $display("FAIL full_5th: rd=%b addr=%h required 1/40", avm_read, avm_address);
    else passed++;
    @(negedge clock);
    req_read_en = 2'b00;
    avm_readdatavalid = 1'b0;
  endtask

  task automatic test_protocol_err();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({req_grant, resp_valid, avm_read, avm_write, protocol_err} !== 7'b0 || avm_address !== '0)
      $display("FAIL midreset_outputs: grant=%b rv=%b rd=%b wr=%b err=%b addr=%h required all 0",
               req_grant, resp_valid, avm_read, avm_write, protocol_err, avm_address);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    avm_readdatavalid = 1'b1;
    avm_readdata = 64'h1234;
    @(posedge clock); #1;
    checks++;
    if (protocol_err !== 1'b1 || resp_valid !== 2'b00)
      $display("FAIL late_resp: err=%b rv=%b required 1/00", protocol_err, resp_valid);
    else passed++;
    @(negedge clock);
    avm_readdatavalid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (protocol_err !== 1'b1 || resp_valid !== 2'b00 || resp_read_data !== '0)
      $display("FAIL err_sticky: err=%b rv=%b data=%h required 1/00/0", protocol_err, resp_valid, resp_read_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_two_reads();
    test_read_responses();
    test_waitrequest_hold();
    test_back_to_back();
    test_fifo_full();
    test_protocol_err();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mp_avm_port_arbiter.md
Name: mp_avm_port_arbiter

Overview:
Shares one Avalon-MM master among NUM_PORTS independent memory-request ports in the multipump memory subsystem, in the same clock domain as the 2x memory clock. Arbitration is round-robin. The block holds a registered command stable through avm_waitrequest and tracks outstanding reads in an in-order port-ID FIFO, so each read response returns to the port that issued it.

Parameters:
NUM_PORTS, 2, number of requesting ports (2..8)
ADDR_WIDTH, 32, Avalon byte address width
DATA_WIDTH, 64, data word width
BE_WIDTH, 8, byte-enable width (DATA_WIDTH/8)
MAX_PENDING, 4, max outstanding reads (power of 2, ≥2)

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high
req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i
req_write_en  in  NUM_PORTS  per-port write request
req_read_en  in  NUM_PORTS  per-port read request
req_byte_en  in  NUM_PORTS*BE_WIDTH  per-port byte enables
req_write_data  in  NUM_PORTS*DATA_WIDTH  per-port write data
req_grant  out  NUM_PORTS  one-hot; request of port i consumed this cycle
resp_valid  out  NUM_PORTS  one-hot; read data for port i valid this cycle
resp_read_data  out  DATA_WIDTH  read data, shared by all ports
avm_address  out  ADDR_WIDTH  Avalon address
avm_write  out  1  Avalon write
avm_read  out  1  Avalon read
avm_byteenable  out  BE_WIDTH  Avalon byte enables
avm_writedata  out  DATA_WIDTH  Avalon write data
avm_waitrequest  in  1  Avalon stall
avm_readdata  in  DATA_WIDTH  Avalon read data
avm_readdatavalid  in  1  Avalon read response strobe
protocol_err  out  1  sticky; readdatavalid seen with no outstanding read

Behaviour:
- Reset: all outputs 0; command register empty; RR pointer selects port 0 as highest priority; FIFO empty; protocol_err cleared.
- Eligible port: write_en=1, or read_en=1 with FIFO not full. Write_en=1 with read_en=1 is treated as a write. A port with neither bit set is idle.
- slot_free = !cmd_valid || !avm_waitrequest. This path is combinational from waitrequest to req_grant.
- When slot_free and any port is eligible: grant the first eligible port at or after the RR pointer (wrapping). Only one req_grant bit is asserted. The command is latched into the avm_* registers at the next edge. The RR pointer moves to granted+1 mod NUM_PORTS.
- Granted read: push port ID into the FIFO at the same edge. Avalon returns responses in issue order, so grant order equals response order.
- avm_* outputs hold constant while avm_waitrequest=1. When the command is accepted and there is no new grant, avm_read and avm_write drop to 0 the next cycle.
- Back-to-back: with waitrequest low and continuous requests, one command is issued per cycle.
- Grant-to-avm latency: 1 cycle.
- Read response: on avm_readdatavalid, pop the FIFO. resp_read_data <= avm_readdata and resp_valid[popped ID] <= 1. The response appears exactly 1 cycle after readdatavalid and lasts 1 cycle.
- readdatavalid with FIFO empty: data dropped, no resp_valid, protocol_err <= 1 (cleared only by reset).
- FIFO full (MAX_PENDING reads outstanding): read-only ports are ineligible and writes still proceed. A push and pop in the same cycle is allowed only when not full. A read is not granted in the cycle the FIFO becomes non-full; it is granted the following cycle.
- Reset mid-operation: command is dropped and the FIFO is cleared. Late responses arriving after reset set protocol_err.

Decomposition:
- Shared package/include: constants for default widths and the MAX_PENDING default, plus a port-ID width macro equal to clog2(NUM_PORTS) (min 1).
- One sub-module: mp_id_fifo, a synchronous FIFO of depth MAX_PENDING storing port IDs, with full/empty flags and async reset.
- The RR arbiter stays inline.

Test Plan:
- Reset, then port 0 reads addr 0x7f and port 1 reads addr 0xff in the same cycle, waitrequest=0 -> grant port 0, then port 1 next cycle; avm_address shows 0x7f then 0xff.
- For those two reads, drive avm_readdata 0xdeadbeef then 0xbeefdead on consecutive readdatavalid cycles -> resp_valid[0] with 0xdeadbeef, then resp_valid[1] with 0xbeefdead, each 1 cycle after its strobe.
- Port 1 writes addr 0x1ff, data 0x0123456789abcdef, byte_en 0x0f; hold waitrequest=1 for 3 cycles -> avm_* stable for 4 cycles, no further grants, then avm_write drops.
- Both ports request continuously for 8 cycles with waitrequest=0 -> grants alternate 0,1,0,1…; each port gets 4 grants.
- Port 0 issues 5 reads with no responses, MAX_PENDING=4 -> 4 grants; the 5th is withheld until one readdatavalid; a write from port 1 is still granted while the FIFO is full.
- readdatavalid with nothing outstanding, and reset asserted while a read is pending -> protocol_err=1, no resp_valid; all outputs 0 during reset.
